mips_multicycle_ctrl: RTL and testbench

Moore-FSM controller that sequences the shared 32-bit ALU, register file, memory and PC of the multicycle MIPS datapath. Each instruction runs as a series of states. Per state, the block drives datapath enables and mux selects, and decodes op/funct into the 3-bit ALU function code F. It sits beside the datapath and observes the ALU Zero flag for branch resolution.

---
 rtl/mips_ctrl_pkg.sv | 52 +++++
 rtl/mips_aludec.sv | 38 +++
 rtl/mips_multicycle_ctrl.sv | 151 +++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// R-type funct codes, ALU operation classes and ALU F codes.
package mips_ctrl_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned FUNCT_W  = 6;
    localparam int unsigned ALUF_W   = 3;
    localparam int unsigned ALUSRC_W = 2;
    localparam int unsigned PCSRC_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } statetype;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALUF_W-1:0] F_AND = 3'b000;
    localparam logic [ALUF_W-1:0] F_OR  = 3'b001;
    localparam logic [ALUF_W-1:0] F_ADD = 3'b010;
    localparam logic [ALUF_W-1:0] F_SUB = 3'b110;
    localparam logic [ALUF_W-1:0] F_SLT = 3'b111;

endpackage

// File: rtl/mips_aludec.sv
// ALU decoder: maps the FSM's ALU operation class and the instruction funct
// field to the 3-bit ALU F code.
//   i_aluop        operation class requested by the current state
//   i_funct        instr[5:0]
//   o_alucontrol   ALU F code
//   o_funct_valid  funct is one of the supported R-type functions
module mips_aludec
    import mips_ctrl_pkg::*;
(
    input  aluop_t              i_aluop,
    input  logic [FUNCT_W-1:0]  i_funct,
    output logic [ALUF_W-1:0]   o_alucontrol,
    output logic                o_funct_valid
);

    logic [ALUF_W-1:0] w_funct_f;

    // Unknown funct falls back to ADD; the FSM uses o_funct_valid to block the write.
    always_comb begin
        w_funct_f     = F_ADD;
        o_funct_valid = 1'b1;
        case (i_funct)
            FN_ADD:  w_funct_f = F_ADD;
            FN_SUB:  w_funct_f = F_SUB;
            FN_AND:  w_funct_f = F_AND;
            FN_OR:   w_funct_f = F_OR;
            FN_SLT:  w_funct_f = F_SLT;
            default: o_funct_valid = 1'b0;
        endcase

        case (i_aluop)
            ALUOP_SUB:   o_alucontrol = F_SUB;
            ALUOP_FUNCT: o_alucontrol = w_funct_f;
            default:     o_alucontrol = F_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM controller for the multicycle MIPS datapath. Outputs are decoded
// combinationally from the state register (plus op/funct); pcen additionally
// folds in the same-cycle ALU zero flag for BEQ.
//   clk, reset     clock, synchronous active-high reset to FETCH
//   op, funct      instruction fields from the instruction register
//   zero           ALU zero flag
//   pcen           PC write enable (pcwrite | branch & zero)
//   memwrite, irwrite, regwrite   datapath write strobes
//   alusrca, alusrcb, alucontrol  ALU operand selects and F code
//   pcsrc, iord, memtoreg, regdst datapath mux selects
//   illegal_op     pulse in DECODE for an unsupported opcode
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OP_W-1:0]      op,
    input  logic [FUNCT_W-1:0]   funct,
    input  logic                 zero,
    output logic                 pcen,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic [ALUSRC_W-1:0]  alusrcb,
    output logic [ALUF_W-1:0]    alucontrol,
    output logic [PCSRC_W-1:0]   pcsrc,
    output logic                 iord,
    output logic                 memtoreg,
    output logic                 regdst,
    output logic                 illegal_op
);

    statetype r_state;
    statetype w_next;
    aluop_t   w_aluop;
    logic     w_pcwrite;
    logic     w_branch;
    logic     w_funct_valid;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and per-state control decode.
    always_comb begin
        w_next     = S_FETCH;
        w_aluop    = ALUOP_ADD;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        iord       = 1'b0;
        memtoreg   = 1'b0;
        regdst     = 1'b0;
        illegal_op = 1'b0;

        case (r_state)
            S_FETCH: begin
                irwrite   = 1'b1;
                w_pcwrite = 1'b1;
                alusrcb   = 2'b01;
                w_next    = S_DECODE;
            end
            S_DECODE: begin
                // Branch target precompute: PC + (signimm << 2).
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JEX;
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord   = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                // Address held on ALUOut while the loaded word is written back.
                iord     = 1'b1;
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                w_aluop = ALUOP_FUNCT;
                w_next  = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = w_funct_valid;
            end
            S_BEQEX: begin
                alusrca  = 1'b1;
                w_aluop  = ALUOP_SUB;
                w_branch = 1'b1;
                pcsrc    = 2'b01;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                w_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite = 1'b1;
            end
            S_JEX: begin
                pcsrc     = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: begin
                // Unused encodings: all strobes stay low, recover to FETCH.
                w_next = S_FETCH;
            end
        endcase
    end

    assign pcen = w_pcwrite | (w_branch & zero);

    mips_aludec u_aludec (
        .i_aluop       (w_aluop),
        .i_funct       (funct),
        .o_alucontrol  (alucontrol),
        .o_funct_valid (w_funct_valid)
    );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: expected output vectors per cycle
// are queued when an instruction is launched and compared at the negedge.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pcen;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memtoreg;
        logic       regdst;
        logic       illegal_op;
    } outs_t;

    typedef struct {
        outs_t e;
        outs_t m;
        string tag;
    } sb_t;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic [2:0] alucontrol;
    logic [1:0] pcsrc;
    logic       iord, memtoreg, regdst, illegal_op;

    sb_t q[$];
    int  total = 0;
    int  bad   = 0;

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .alucontrol (alucontrol),
        .pcsrc      (pcsrc),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected F code and validity of an R-type funct.
    function automatic logic [3:0] funct_model(input logic [5:0] f);
        case (f)
            6'b100000: return {1'b1, 3'b010};
            6'b100010: return {1'b1, 3'b110};
            6'b100100: return {1'b1, 3'b000};
            6'b100101: return {1'b1, 3'b001};
            6'b101010: return {1'b1, 3'b111};
            default:   return {1'b0, 3'b010};
        endcase
    endfunction

    // Queue expected outputs of one state; mask marks fields defined in that state.
    task automatic push(input string s, input string tag);
        sb_t        x;
        logic [3:0] fm;
        fm = funct_model(funct);
        x.e = '0;
        x.m = '0;
        x.tag = {tag, ".", s};
        x.m.pcen = 1'b1; x.m.memwrite = 1'b1; x.m.irwrite = 1'b1;
        x.m.regwrite = 1'b1; x.m.illegal_op = 1'b1;
        case (s)
            "FETCH": begin
                x.e.irwrite = 1'b1; x.e.pcen = 1'b1;
                x.e.alusrcb = 2'b01; x.e.alucontrol = 3'b010;
                x.m.alusrca = 1'b1; x.m.alusrcb = 2'b11; x.m.alucontrol = 3'b111;
                x.m.pcsrc = 2'b11; x.m.iord = 1'b1;
            end
            "DECODE", "ILLDEC": begin
                x.e.alusrcb = 2'b11; x.e.alucontrol = 3'b010;
                x.e.illegal_op = (s == "ILLDEC");
                x.m.alusrca = 1'b1; x.m.alusrcb = 2'b11; x.m.alucontrol = 3'b111;
            end
            "MEMADR", "ADDIEX": begin
                x.e.alusrca = 1'b1; x.e.alusrcb = 2'b10; x.e.alucontrol = 3'b010;
                x.m.alusrca = 1'b1; x.m.alusrcb = 2'b11; x.m.alucontrol = 3'b111;
            end
            "MEMRD": begin
                x.e.iord = 1'b1; x.m.iord = 1'b1;
            end
            "MEMWB": begin
                x.e.iord = 1'b1; x.e.memtoreg = 1'b1; x.e.regwrite = 1'b1;
                x.m.iord = 1'b1; x.m.memtoreg = 1'b1; x.m.regdst = 1'b1;
            end
            "MEMWR": begin
                x.e.iord = 1'b1; x.e.memwrite = 1'b1; x.m.iord = 1'b1;
            end
            "RTYPEEX": begin
                x.e.alusrca = 1'b1; x.e.alucontrol = fm[2:0];
                x.m.alusrca = 1'b1; x.m.alusrcb = 2'b11; x.m.alucontrol = 3'b111;
            end
            "RTYPEWB": begin
                x.e.regdst = 1'b1; x.e.regwrite = fm[3];
                x.m.regdst = 1'b1; x.m.memtoreg = 1'b1;
            end
            "BEQEX": begin
                x.e.alusrca = 1'b1; x.e.alucontrol = 3'b110;
                x.e.pcsrc = 2'b01; x.e.pcen = zero;
                x.m.alusrca = 1'b1; x.m.alusrcb = 2'b11; x.m.alucontrol = 3'b111;
                x.m.pcsrc = 2'b11;
            end
            "ADDIWB": begin
                x.e.regwrite = 1'b1; x.m.regdst = 1'b1; x.m.memtoreg = 1'b1;
            end
            "JEX": begin
                x.e.pcsrc = 2'b10; x.e.pcen = 1'b1; x.m.pcsrc = 2'b11;
            end
            default: ;
        endcase
        q.push_back(x);
    endtask

    // Pop one expectation and compare at the negedge.
    task automatic chk_one();
        sb_t   x;
        outs_t o;
        @(negedge clk);
        x = q.pop_front();
        o = {pcen, memwrite, irwrite, regwrite, alusrca, alusrcb, alucontrol,
             pcsrc, iord, memtoreg, regdst, illegal_op};
        total++;
        assert ((o & x.m) === (x.e & x.m)) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h mask=%h", x.tag, o, x.e, x.m);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        while (q.size() > 0) begin
            chk_one();
            adv();
        end
    endtask

    // Launch one instruction from FETCH and check every cycle until FETCH returns.
    task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z,
                       input string tag);
        op = o; funct = f; zero = z;
        push("FETCH", tag);
        case (o)
            6'b100011: begin push("DECODE", tag); push("MEMADR", tag);
                             push("MEMRD", tag); push("MEMWB", tag); end
            6'b101011: begin push("DECODE", tag); push("MEMADR", tag);
                             push("MEMWR", tag); end
            6'b000000: begin push("DECODE", tag); push("RTYPEEX", tag);
                             push("RTYPEWB", tag); end
            6'b000100: begin push("DECODE", tag); push("BEQEX", tag); end
            6'b001000: begin push("DECODE", tag); push("ADDIEX", tag);
                             push("ADDIWB", tag); end
            6'b000010: begin push("DECODE", tag); push("JEX", tag); end
            default:   push("ILLDEC", tag);
        endcase
        drain();
    endtask

    initial begin
        reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;
        adv();
        push("FETCH", "reset");
        chk_one();
        adv();
        reset = 1'b0;

        run(6'b100011, 6'd0, 1'b0, "lw");

        // Reset while LW sits in MEMRD.
        op = 6'b100011; funct = 6'd0; zero = 1'b0;
        push("FETCH", "lw_rst"); push("DECODE", "lw_rst"); push("MEMADR", "lw_rst");
        drain();
        push("MEMRD", "lw_rst");
        chk_one();
        reset = 1'b1;
        adv();
        push("FETCH", "in_rst");
        chk_one();
        adv();
        push("FETCH", "in_rst2");
        chk_one();
        adv();
        reset = 1'b0;

        run(6'b000000, 6'b101010, 1'b0, "slt");
        run(6'b000000, 6'b100100, 1'b0, "and");
        run(6'b000000, 6'b100101, 1'b0, "or");
        run(6'b000000, 6'b100010, 1'b1, "sub");
        run(6'b000000, 6'b111111, 1'b0, "badfn");
        run(6'b000100, 6'd0, 1'b1, "beq_t");
        run(6'b000100, 6'd0, 1'b0, "beq_nt");
        run(6'b111111, 6'd0, 1'b0, "illop");
        run(6'b101011, 6'd0, 1'b0, "sw");
        run(6'b000010, 6'd0, 1'b0, "j");
        run(6'b001000, 6'd0, 1'b0, "addi");
        run(6'b000001, 6'd0, 1'b1, "illop2");
        run(6'b100011, 6'd0, 1'b1, "lw2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
